sparse_systolic_tile: RTL and testbench
=======================================

// Module: sparse_systolic_tile
// PURPOSE
//  Parametrised weight-stationary INT systolic tile for BSR sparse GEMM, N_ROWS x N_COLS PEs.
//  Adds over the fixed 14x14 array: double-buffered weights (shadow bank fills while active computes),
//  cmd/act valid-ready handshakes with stall, internal FSM with auto skew-flush, done pulse, block/skip stats.
//  Sits between the BSR scheduler (cmd, weight rows) and the activation buffer; accumulators read by output unit.
// PARAMETERS
//  N_ROWS   14  PE rows = activation lanes = weight rows per block
//  N_COLS   14  PE columns = weight lanes
//  DATA_W   8   signed activation/weight width
//  ACC_W    32  signed accumulator width (>= 2*DATA_W)
//  LEN_W    16  width of cmd_len (activation vectors per block)
//  CNT_W    32  width of statistics counters
// PORTS
//  clk           in   1                     clock, all state on rising edge
//  rst_n         in   1                     async active-low reset
//  wload_valid   in   1                     weight row offered to shadow bank
//  wload_ready   out  1                     shadow bank accepting rows
//  wload_row     in   N_COLS*DATA_W         one weight row, lane c at [c*DATA_W +: DATA_W]
//  cmd_valid     in   1                     block command offered
//  cmd_ready     out  1                     command accepted this cycle when both high
//  cmd_zero      in   1                     1 = zero BSR block, skip compute
//  cmd_len       in   LEN_W                 activation vectors to stream for this block
//  act_valid     in   1                     activation vector offered
//  act_ready     out  1                     high only in STREAM
//  act_in        in   N_ROWS*DATA_W         activation vector, row r at [r*DATA_W +: DATA_W]
//  clr           in   1                     sync clear of all accumulators (IDLE only)
//  busy          out  1                     FSM not in IDLE
//  done          out  1                     1-cycle pulse: block finished or skipped
//  blk_cnt       out  CNT_W                 computed (non-zero) blocks completed
//  skip_cnt      out  CNT_W                 zero blocks skipped
//  acc_out       out  N_ROWS*N_COLS*ACC_W   PE (r,c) at [(r*N_COLS+c)*ACC_W +: ACC_W]
// BEHAVIOUR
//  Reset: all outputs 0 except wload_ready=1; FSM IDLE; shadow/active weights, skew regs, accs, counters 0.
//  Reset mid-operation aborts the block; no done pulse is produced.
//  Shadow fill: row accepted on wload_valid&&wload_ready into row wptr, wptr++; after row N_ROWS-1
//   shadow_full=1, wptr=0, wload_ready=0. wload_ready = !shadow_full. Filling is legal in any FSM state.
//  cmd_ready = IDLE && (cmd_zero || shadow_full); clr has priority: cmd_ready=0 in a cycle with clr=1.
//  FSM: IDLE -> (cmd accepted, cmd_zero=1) -> SKIP -> IDLE. SKIP lasts 1 cycle: done=1, skip_cnt++, accs unchanged.
//       IDLE -> (cmd accepted, cmd_zero=0) -> SWAP: shadow copied to all PE weights in one cycle,
//       shadow_full cleared (a new row may be accepted the following cycle); remaining=cmd_len.
//       SWAP -> STREAM if remaining!=0 else FLUSH.
//       STREAM: act_ready=1; each act handshake advances the array one step, remaining--;
//       act_valid=0 freezes skew regs, a-forward regs and accs (stall). Last handshake -> FLUSH.
//       FLUSH: FLUSH_LEN=N_ROWS+N_COLS-1 cycles, zeros injected into the skew. Then DONE.
//       DONE: 1 cycle, done=1, blk_cnt++ -> IDLE.
//  cmd_len=0: SWAP, FLUSH, DONE; accs unchanged; blk_cnt still increments.
//  Latency: done asserts FLUSH_LEN+1 cycles after the last act handshake. acc_out is final when done=1.
//  Skew: row r delayed r array steps; PE passes a right with 1-step delay.
//  Arithmetic: acc += sext(a*w), the 2*DATA_W signed product sign-extended to ACC_W; wraps mod 2^ACC_W.
//  clr: honoured only in IDLE, zeroes accs next cycle; ignored otherwise. Accs persist across blocks (k-tiling).
//  Counters wrap mod 2^CNT_W and are cleared only by reset.
//  cmd_valid while busy: held off (cmd_ready=0); cmd fields sampled only at handshake.
// STRUCTURE
//  systolic_pkg: tile_state_e {IDLE,SKIP,SWAP,STREAM,FLUSH,DONE}; function flush_len(N_ROWS,N_COLS).
//  Sub-module pe_wload: weight reg with parallel load, en-gated a-forward reg, MAC acc with clr; 1 per PE.
//  Tile holds shadow bank, skew line, FSM, remaining counter, stat counters.
// TESTING
//  Identity weights loaded, cmd_len=1, act r=r+1 -> after done acc(r,c)= (r+1) if r==c else 0; blk_cnt=1.
//  cmd_zero=1 with empty shadow -> cmd_ready=1, done next cycle, skip_cnt=1, acc_out unchanged, wload_ready=1.
//  All weights 127, acts -128, cmd_len=4 with act_valid toggled 1/0 -> each acc=-65024; done FLUSH_LEN+1 after last act.
//  Second block's weights streamed during first block's STREAM -> shadow_full=1 by DONE; back-to-back cmd accepted in IDLE.
//  Accumulate two blocks without clr (W=1, a=2; then W=3, a=1) -> acc=5; clr in IDLE -> acc=0; clr in STREAM ignored.
//  Assert rst_n low mid-STREAM -> next cycle all accs, counters 0, busy=0, wload_ready=1, no done pulse.

Source files
------------

// File: rtl/sparse_systolic_tile_pkg.sv
// Shared types and helpers for the sparse systolic tile.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SKIP,
    SWAP,
    STREAM,
    FLUSH,
    DONE
  } tile_state_e;

  // Array steps needed to drain the last skewed vector through the far corner PE.
  function automatic int unsigned flush_len(input int unsigned n_rows, input int unsigned n_cols);
    return n_rows + n_cols - 1;
  endfunction

endpackage

// File: rtl/sparse_systolic_tile_pe.sv
// Weight-stationary PE: loadable weight register, step-gated activation forward
// register and signed MAC accumulator with synchronous clear.
module pe_wload #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] w_in,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] a_in,
  output logic [DATA_W-1:0] a_out,
  output logic [ACC_W-1:0]  acc
);

  logic signed [DATA_W-1:0]   w_q;
  logic signed [DATA_W-1:0]   a_s;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;

  assign a_s      = $signed(a_in);
  assign prod     = (2*DATA_W)'(a_s) * (2*DATA_W)'(w_q);
  assign prod_ext = ACC_W'(prod);

  // Stationary weight, replaced from the shadow bank on swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0;
    end else if (load) begin
      w_q <= w_in;
    end
  end

  // Pass the activation to the right neighbour one array step later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out <= '0;
    end else if (en) begin
      a_out <= a_in;
    end
  end

  // Accumulate the sign-extended product on every array step; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/sparse_systolic_tile.sv
// Weight-stationary systolic tile for BSR sparse GEMM with a double-buffered
// weight bank, cmd/act handshakes, automatic skew flush and block/skip stats.
module sparse_systolic_tile
  import systolic_pkg::*;
#(
  parameter int unsigned N_ROWS = 14,
  parameter int unsigned N_COLS = 14,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wload_valid,
  output logic                             wload_ready,
  input  logic [N_COLS*DATA_W-1:0]         wload_row,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_zero,
  input  logic [LEN_W-1:0]                 cmd_len,
  input  logic                             act_valid,
  output logic                             act_ready,
  input  logic [N_ROWS*DATA_W-1:0]         act_in,
  input  logic                             clr,
  output logic                             busy,
  output logic                             done,
  output logic [CNT_W-1:0]                 blk_cnt,
  output logic [CNT_W-1:0]                 skip_cnt,
  output logic [N_ROWS*N_COLS*ACC_W-1:0]   acc_out
);

  localparam int unsigned FLUSH_LEN = flush_len(N_ROWS, N_COLS);
  localparam int unsigned FL_W      = $clog2(FLUSH_LEN + 1);
  localparam int unsigned WP_W      = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

  tile_state_e state_q, state_d;

  logic [N_COLS*DATA_W-1:0] shadow [N_ROWS];
  logic [WP_W-1:0]          wptr;
  logic                     shadow_full;
  logic [LEN_W-1:0]         remaining;
  logic [FL_W-1:0]          flush_cnt;
  logic                     cmd_accept;
  logic                     step;
  logic                     pe_clr;
  logic                     pe_load;
  logic [DATA_W-1:0]        a_h [N_ROWS][N_COLS+1];

  assign wload_ready = !shadow_full;
  assign cmd_accept  = cmd_valid && cmd_ready;
  // One array step per accepted activation, or every cycle while draining.
  assign step        = ((state_q == STREAM) && act_valid) || (state_q == FLUSH);
  assign pe_clr      = (state_q == IDLE) && clr;
  assign pe_load     = (state_q == SWAP);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    act_ready = 1'b0;
    done      = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        cmd_ready = (cmd_zero || shadow_full) && !clr;
        if (cmd_valid && cmd_ready) begin
          state_d = cmd_zero ? SKIP : SWAP;
        end
      end
      SKIP: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      SWAP: begin
        state_d = (remaining != '0) ? STREAM : FLUSH;
      end
      STREAM: begin
        act_ready = 1'b1;
        if (act_valid && (remaining == LEN_W'(1))) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_cnt == FL_W'(FLUSH_LEN - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shadow bank fill; the swap frees it for the next block's rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr        <= '0;
      shadow_full <= 1'b0;
      for (int unsigned i = 0; i < N_ROWS; i++) begin
        shadow[i] <= '0;
      end
    end else if (state_q == SWAP) begin
      shadow_full <= 1'b0;
    end else if (wload_valid && !shadow_full) begin
      shadow[wptr] <= wload_row;
      if (wptr == WP_W'(N_ROWS - 1)) begin
        wptr        <= '0;
        shadow_full <= 1'b1;
      end else begin
        wptr <= wptr + WP_W'(1);
      end
    end
  end

  // Block length and flush countdowns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
      flush_cnt <= '0;
    end else begin
      if (cmd_accept) begin
        remaining <= cmd_len;
      end else if ((state_q == STREAM) && act_valid) begin
        remaining <= remaining - LEN_W'(1);
      end
      if (state_q == FLUSH) begin
        flush_cnt <= flush_cnt + FL_W'(1);
      end else begin
        flush_cnt <= '0;
      end
    end
  end

  // Completed-block and skipped-block statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt  <= '0;
      skip_cnt <= '0;
    end else begin
      if (state_q == DONE) begin
        blk_cnt <= blk_cnt + CNT_W'(1);
      end
      if (state_q == SKIP) begin
        skip_cnt <= skip_cnt + CNT_W'(1);
      end
    end
  end

  genvar gr, gc;
  for (gr = 0; gr < N_ROWS; gr++) begin : g_row
    logic [DATA_W-1:0] src;
    // Outside STREAM the skew line is fed zeros so the flush drains it cleanly.
    assign src = (state_q == STREAM) ? act_in[gr*DATA_W +: DATA_W] : '0;

    if (gr == 0) begin : g_nodly
      assign a_h[gr][0] = src;
    end else begin : g_dly
      logic [DATA_W-1:0] sk [gr];
      // Row delay line of gr array steps.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < gr; i++) begin
            sk[i] <= '0;
          end
        end else if (step) begin
          sk[0] <= src;
          for (int unsigned i = 1; i < gr; i++) begin
            sk[i] <= sk[i-1];
          end
        end
      end
      assign a_h[gr][0] = sk[gr-1];
    end

    for (gc = 0; gc < N_COLS; gc++) begin : g_col
      pe_wload #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (pe_load),
        .w_in  (shadow[gr][gc*DATA_W +: DATA_W]),
        .en    (step),
        .clr   (pe_clr),
        .a_in  (a_h[gr][gc]),
        .a_out (a_h[gr][gc+1]),
        .acc   (acc_out[(gr*N_COLS+gc)*ACC_W +: ACC_W])
      );
    end
  end

endmodule

// File: tb/tb_sparse_systolic_tile.sv
// Self-checking bench for sparse_systolic_tile on a 4x5 tile. The reference
// model treats each block as a plain matrix product: acc(r,c) += sum_k a_k[r]*W[r][c].
module tb_sparse_systolic_tile;

  localparam int R  = 4;
  localparam int C  = 5;
  localparam int DW = 8;
  localparam int AW = 32;
  localparam int LW = 16;
  localparam int CW = 32;
  localparam int FL = R + C - 1;

  logic              clk;
  logic              rst_n;
  logic              wload_valid;
  logic              wload_ready;
  logic [C*DW-1:0]   wload_row;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_zero;
  logic [LW-1:0]     cmd_len;
  logic              act_valid;
  logic              act_ready;
  logic [R*DW-1:0]   act_in;
  logic              clr;
  logic              busy;
  logic              done;
  logic [CW-1:0]     blk_cnt;
  logic [CW-1:0]     skip_cnt;
  logic [R*C*AW-1:0] acc_out;

  int tests  = 0;
  int failed = 0;

  int shadow_m [R][C];
  int act_w    [R][C];
  int acc_m    [R][C];
  int nxt_w    [R][C];
  int av       [16][R];
  int blk_m  = 0;
  int skip_m = 0;

  sparse_systolic_tile #(
    .N_ROWS (R),
    .N_COLS (C),
    .DATA_W (DW),
    .ACC_W  (AW),
    .LEN_W  (LW),
    .CNT_W  (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wload_valid (wload_valid),
    .wload_ready (wload_ready),
    .wload_row   (wload_row),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_zero    (cmd_zero),
    .cmd_len     (cmd_len),
    .act_valid   (act_valid),
    .act_ready   (act_ready),
    .act_in      (act_in),
    .clr         (clr),
    .busy        (busy),
    .done        (done),
    .blk_cnt     (blk_cnt),
    .skip_cnt    (skip_cnt),
    .acc_out     (acc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached (observed running, required finished)");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int acc_at(input int r, input int c);
    logic [AW-1:0] v;
    v = acc_out[(r*C+c)*AW +: AW];
    return int'(v);
  endfunction

  task automatic chk_accs(input string tag);
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        chk($sformatf("%s(%0d,%0d)", tag, r, c), acc_at(r, c), acc_m[r][c]);
      end
    end
  endtask

  function automatic logic [C*DW-1:0] wrow(input int r);
    logic [C*DW-1:0] v;
    v = '0;
    for (int c = 0; c < C; c++) v[c*DW +: DW] = DW'(nxt_w[r][c]);
    return v;
  endfunction

  function automatic logic [R*DW-1:0] arow(input int k);
    logic [R*DW-1:0] v;
    v = '0;
    for (int r = 0; r < R; r++) v[r*DW +: DW] = DW'(av[k][r]);
    return v;
  endfunction

  task automatic drive_wl(input int pr);
    if (pr < R) begin
      wload_valid = 1'b1;
      wload_row   = wrow(pr);
    end else begin
      wload_valid = 1'b0;
    end
  endtask

  // Fill the shadow bank with nxt_w, one row per accepted handshake.
  task automatic load_shadow();
    int n;
    for (int r = 0; r < R; r++) begin
      drive_wl(r);
      n = 0;
      while (!wload_ready && n < 100) begin
        tick();
        n++;
      end
      chk("wload_ready_wait", int'(wload_ready), 1);
      tick();
      for (int c = 0; c < C; c++) shadow_m[r][c] = nxt_w[r][c];
    end
    wload_valid = 1'b0;
  endtask

  task automatic issue_cmd(input bit zero, input int len, output int waited);
    cmd_valid = 1'b1;
    cmd_zero  = zero;
    cmd_len   = LW'(len);
    #1;
    waited = 0;
    while (!cmd_ready && waited < 50) begin
      tick();
      waited++;
    end
    chk("cmd_ready", int'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
    cmd_zero  = 1'b0;
  endtask

  // mode 0: act_valid always high, 1: toggled 1/0, 2: random.
  task automatic run_block(input int len, input int mode, input bit preload, input bit clr_s);
    int w8, n, k, pr, m;
    bit hs, wl;
    issue_cmd(1'b0, len, w8);
    chk("cmd_wait", w8, 0);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) act_w[r][c] = shadow_m[r][c];
    chk("swap_busy", int'(busy), 1);
    chk("swap_act_ready", int'(act_ready), 0);
    k  = 0;
    n  = 0;
    pr = preload ? 0 : R;
    while (k < len && n < 200) begin
      case (mode)
        0:       act_valid = 1'b1;
        1:       act_valid = (n % 2 == 0);
        default: act_valid = 1'($urandom_range(0, 1));
      endcase
      act_in = arow(k);
      clr    = clr_s;
      drive_wl(pr);
      #1;
      hs = act_valid && act_ready;
      wl = wload_valid && wload_ready;
      tick();
      n++;
      if (hs) begin
        for (int r = 0; r < R; r++)
          for (int c = 0; c < C; c++) acc_m[r][c] += av[k][r] * act_w[r][c];
        k++;
      end
      if (wl) begin
        for (int c = 0; c < C; c++) shadow_m[pr][c] = nxt_w[pr][c];
        pr++;
      end
    end
    act_valid = 1'b0;
    clr       = 1'b0;
    chk("act_handshakes", k, len);
    // m counts edges after the last handshake edge; the handshake cycle is cycle 0.
    m = 0;
    while (!done && m < 100) begin
      drive_wl(pr);
      #1;
      wl = wload_valid && wload_ready;
      tick();
      m++;
      if (wl) begin
        for (int c = 0; c < C; c++) shadow_m[pr][c] = nxt_w[pr][c];
        pr++;
      end
    end
    wload_valid = 1'b0;
    chk("done", int'(done), 1);
    if (len > 0) chk("done_latency", m + 1, FL + 1);
    if (preload) chk("shadow_full_at_done", int'(wload_ready), 0);
    chk_accs("acc_blk");
    tick();
    chk("done_pulse", int'(done), 0);
    blk_m++;
    chk("blk_cnt", int'(blk_cnt), blk_m);
    chk("busy_idle", int'(busy), 0);
  endtask

  task automatic do_skip(input bit check_empty);
    int w8;
    issue_cmd(1'b1, int'($urandom_range(0, 9)), w8);
    chk("skip_done", int'(done), 1);
    tick();
    chk("skip_done_pulse", int'(done), 0);
    skip_m++;
    chk("skip_cnt", int'(skip_cnt), skip_m);
    chk("skip_blk_cnt", int'(blk_cnt), blk_m);
    chk_accs("acc_skip");
    if (check_empty) chk("skip_wload_ready", int'(wload_ready), 1);
  endtask

  // clr in IDLE with a command offered: command must be held off, accs cleared.
  task automatic do_clr();
    cmd_valid = 1'b1;
    cmd_zero  = 1'b1;
    clr       = 1'b1;
    #1;
    chk("clr_cmd_ready", int'(cmd_ready), 0);
    tick();
    cmd_valid = 1'b0;
    cmd_zero  = 1'b0;
    clr       = 1'b0;
    chk("clr_not_busy", int'(busy), 0);
    chk("clr_skip_cnt", int'(skip_cnt), skip_m);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) acc_m[r][c] = 0;
    chk_accs("acc_clr");
  endtask

  task automatic fill_nxt(input int mode, input int val);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        case (mode)
          0:       nxt_w[r][c] = val;
          1:       nxt_w[r][c] = (r == c) ? 1 : 0;
          default: nxt_w[r][c] = int'($urandom_range(0, 255)) - 128;
        endcase
  endtask

  initial begin
    int w8, len, dn;
    rst_n       = 1'b0;
    wload_valid = 1'b0;
    wload_row   = '0;
    cmd_valid   = 1'b0;
    cmd_zero    = 1'b0;
    cmd_len     = '0;
    act_valid   = 1'b0;
    act_in      = '0;
    clr         = 1'b0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        acc_m[r][c] = 0;
        shadow_m[r][c] = 0;
        act_w[r][c] = 0;
      end
    tick(); tick(); tick();

    // Reset state
    chk("rst_wload_ready", int'(wload_ready), 1);
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_act_ready", int'(act_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_blk_cnt", int'(blk_cnt), 0);
    chk("rst_skip_cnt", int'(skip_cnt), 0);
    chk_accs("rst_acc");
    rst_n = 1'b1;
    tick();

    // Zero block with an empty shadow bank
    do_skip(1'b1);

    // Identity weights, one vector a[r]=r+1
    fill_nxt(1, 0);
    load_shadow();
    for (int r = 0; r < R; r++) av[0][r] = r + 1;
    run_block(1, 0, 1'b0, 1'b0);
    chk("acc_ident_diag", acc_at(2, 2), 3);
    chk("acc_ident_off", acc_at(2, 3), 0);
    do_clr();

    // Extreme operands with stalls, next block's weights preloaded during compute
    fill_nxt(0, 127);
    load_shadow();
    fill_nxt(0, 1);
    for (int k = 0; k < 4; k++)
      for (int r = 0; r < R; r++) av[k][r] = -128;
    run_block(4, 1, 1'b1, 1'b0);
    chk("acc_extreme", acc_at(R-1, C-1), -65024);
    do_clr();

    // Back-to-back block on preloaded W=1, a=2; then W=3, a=1 without clr
    for (int r = 0; r < R; r++) av[0][r] = 2;
    run_block(1, 0, 1'b0, 1'b0);
    fill_nxt(0, 3);
    load_shadow();
    for (int r = 0; r < R; r++) av[0][r] = 1;
    run_block(1, 0, 1'b0, 1'b0);
    chk("acc_ktile", acc_at(0, 0), 5);

    // Randomised blocks, some zero-skips, clr sometimes held during STREAM
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_skip(1'b1);
      end else begin
        fill_nxt(2, 0);
        load_shadow();
        len = int'($urandom_range(1, 6));
        for (int k = 0; k < len; k++)
          for (int r = 0; r < R; r++) av[k][r] = int'($urandom_range(0, 255)) - 128;
        run_block(len, 2, 1'b0, 1'($urandom_range(0, 1)));
      end
    end

    // cmd_len = 0: accs unchanged, block still counted
    fill_nxt(2, 0);
    load_shadow();
    run_block(0, 0, 1'b0, 1'b0);

    // clr while a full shadow bank is waiting
    fill_nxt(2, 0);
    load_shadow();
    do_clr();

    // Reset in the middle of STREAM
    issue_cmd(1'b0, 6, w8);
    act_valid = 1'b1;
    act_in    = {R{8'h35}};
    tick(); tick(); tick();
    chk("mid_busy_before", int'(busy), 1);
    rst_n     = 1'b0;
    act_valid = 1'b0;
    tick();
    blk_m  = 0;
    skip_m = 0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) acc_m[r][c] = 0;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_wload_ready", int'(wload_ready), 1);
    chk("mid_rst_act_ready", int'(act_ready), 0);
    chk("mid_rst_blk_cnt", int'(blk_cnt), 0);
    chk("mid_rst_skip_cnt", int'(skip_cnt), 0);
    chk_accs("mid_rst_acc");
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < FL + 4; i++) begin
      tick();
      if (done) dn++;
    end
    chk("mid_rst_no_done", dn, 0);
    chk("mid_rst_idle", int'(busy), 0);

    // Normal operation after the abort
    fill_nxt(2, 0);
    load_shadow();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < R; r++) av[k][r] = int'($urandom_range(0, 255)) - 128;
    run_block(2, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
